// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART 8N1 serialiser, LSB first
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 5208,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               wr_en, pop, is_full, bit_end;

    // Full is judged on the pre-edge count, so a same-cycle pop cannot rescue a write.
    assign is_full = (count_q == FULL_CNT);
    assign wr_en   = tx_ready && !is_full;
    assign bit_end = (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d     = 1'b1;
                bit_cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    idx_d     = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        busy_d = (state_q != IDLE) || (count_q != '0);
        full_d = (count_d == FULL_CNT);
        ovf_d  = ovf_q || (tx_ready && is_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign txd       = txd_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       txd, busy, fifo_full, overflow;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .txd      (txd),
        .busy     (busy),
        .fifo_full(fifo_full),
        .overflow (overflow)
    );

    task automatic pulse(input logic [7:0] b, input bit expect_tx);
        tx_ready = 1'b1;
        tx_data  = b;
        if (expect_tx) exp_q.push_back(b);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    // Waits for a start bit, then checks n frames back to back against the scoreboard.
    task automatic check_frames(input int n, output time t_start);
        int w;
        int bad;
        int first_bad;
        logic [7:0] b;
        logic [9:0] fr;
        t_start = 0;
        w = 0;
        @(negedge clk);
        while (txd !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 300) begin
            n_fail++;
            $display("FAIL frame_start: txd=%b after %0d cycles, required 0", txd, w);
            return;
        end
        t_start = $time;
        for (int f = 0; f < n; f++) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: frame %0d has no expected byte, required one queued", f);
                return;
            end
            b = exp_q.pop_front();
            fr = {1'b1, b, 1'b0};
            bad = 0;
            first_bad = -1;
            for (int k = 0; k < 10 * CPB; k++) begin
                if (f != 0 || k != 0) @(negedge clk);
                if (txd !== fr[k / CPB] || busy !== 1'b1) begin
                    if (bad == 0) first_bad = k;
                    bad++;
                end
            end
            if (bad != 0) begin
                n_fail++;
                $display("FAIL frame_%0d: byte %h has %0d bad txd/busy samples (first at cycle %0d), required 0",
                         f, b, bad, first_bad);
            end
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks += 4;
        if (txd !== 1'b1)       begin n_fail++; $display("FAIL reset_txd: got %b, required 1", txd); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", fifo_full); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle_line;
        int bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_line: %0d bad samples, required 0", bad); end
    endtask

    task automatic test_single_byte;
        time t_e0;
        time ts;
        @(posedge clk);
        #1;
        pulse(8'hA5, 1'b1);
        t_e0 = $time - 1;
        check_frames(1, ts);
        n_checks++;
        if (ts - t_e0 != 15) begin
            n_fail++;
            $display("FAIL single_latency: start %0t after E0, required 15", ts - t_e0);
        end
        @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL single_idle_txd: got %b, required 1", txd); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_back_to_back;
        time ts;
        bit full_seen = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                pulse(8'h00, 1'b1);
                pulse(8'h03, 1'b1);
                pulse(8'h00, 1'b1);
                pulse(8'h01, 1'b1);
            end
            check_frames(4, ts);
            repeat (340) begin
                @(negedge clk);
                if (fifo_full) full_seen = 1'b1;
            end
        join
        n_checks += 3;
        if (full_seen) begin n_fail++; $display("FAIL burst_full: fifo_full seen 1, required 0"); end
        if (txd !== 1'b1) begin n_fail++; $display("FAIL burst_idle_txd: got %b, required 1", txd); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_overflow;
        time ts;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 5; i++) pulse(8'h10 + 8'(i), 1'b1);
                pulse(8'h15, 1'b0);
                @(negedge clk);
                n_checks += 2;
                if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b, required 1", fifo_full); end
                if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
            end
            check_frames(5, ts);
        join
        repeat (3) @(negedge clk);
        n_checks += 4;
        if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL ovf_full_after: got %b, required 0", fifo_full); end
        if (txd !== 1'b1)       begin n_fail++; $display("FAIL ovf_idle_txd: got %b, required 1", txd); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL ovf_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_simultaneous;
        time ts;
        @(posedge clk);
        #1;
        fork
            begin
                pulse(8'h11, 1'b1);
                pulse(8'h22, 1'b1);
                repeat (79) @(posedge clk);
                #1;
                pulse(8'h7E, 1'b1);
            end
            check_frames(3, ts);
        join
        repeat (2) @(negedge clk);
        n_checks += 2;
        if (txd !== 1'b1)  begin n_fail++; $display("FAIL simul_idle_txd: got %b, required 1", txd); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid_frame;
        time t_e0;
        time ts;
        @(posedge clk);
        #1;
        pulse(8'hC3, 1'b0);
        repeat (36) @(posedge clk);
        #3;
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: got %b, required 0", txd); end
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (txd !== 1'b1)       begin n_fail++; $display("FAIL mid_rst_txd: got %b, required 1", txd); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_ovf: got %b, required 0", overflow); end
        if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_full: got %b, required 0", fifo_full); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        pulse(8'h5A, 1'b1);
        t_e0 = $time - 1;
        check_frames(1, ts);
        n_checks++;
        if (ts - t_e0 != 15) begin
            n_fail++;
            $display("FAIL mid_latency: start %0t after E0, required 15", ts - t_e0);
        end
    endtask

    initial begin
        test_reset;
        test_idle_line;
        test_single_byte;
        test_back_to_back;
        test_overflow;
        test_simultaneous;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmit back end. Sits directly downstream of the division control block and consumes its tx_ready/tx_data byte strobes.
- Buffers up to FIFO_DEPTH bytes so the quotient/remainder bytes are never lost while a frame is on the wire.
- Serialises each byte as UART 8N1, LSB first, onto txd.

Parameters:
- CLK_PER_BIT, 5208: clk cycles per bit period (50 MHz / 9600 baud).
- FIFO_DEPTH, 4: buffer entries; power of two, at least 2.
- ADDR_W, 2: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_ready  input  1  byte-valid strobe from the control block, nominally one cycle wide. Every cycle it is high is one write.
- tx_data  input  8  byte accompanying tx_ready.
- txd  output  1  serial line, idle high.
- busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE.
- fifo_full  output  1  high when count == FIFO_DEPTH.
- overflow  output  1  sticky; set when a write is dropped, cleared only by rst.

Behaviour:
Reset:
- rst low forces, asynchronously, txd=1, busy=0, fifo_full=0, overflow=0.
- Reset also clears pointers and count, and sets the FSM to IDLE.
- Reset mid-frame aborts the frame immediately; there is no partial-stop completion.

FIFO:
- Write when tx_ready=1 and count<FIFO_DEPTH: store tx_data at wr_ptr, wr_ptr+1 modulo FIFO_DEPTH.
- If tx_ready=1 and count==FIFO_DEPTH, the byte is dropped and overflow<=1. This holds even if a pop occurs in the same cycle, because full is judged on the pre-edge count.
- Pop is issued by the FSM only; rd_ptr+1 modulo FIFO_DEPTH.
- count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop. count width is ADDR_W+1.
- Pop is never issued when empty. A write into an empty FIFO is not visible to the FSM until the next edge.

FSM states: IDLE, START, DATA, STOP.
- Counters: bit_cnt (0..CLK_PER_BIT-1) and idx (0..7).
- IDLE: txd=1. If count!=0, pop, load shift register with the head byte, txd<=0, bit_cnt<=0, go to START.
  - Latency: tx_ready sampled at edge E0 into an empty FIFO gives txd low after edge E1.
- START: txd=0 for CLK_PER_BIT cycles. At bit_cnt==CLK_PER_BIT-1: txd<=shift[0], idx<=0, go to DATA.
- DATA: each bit held CLK_PER_BIT cycles. At bit end, shift right, idx+1, txd<=next bit. After idx==7 expires: txd<=1, go to STOP.
- STOP: txd=1 for CLK_PER_BIT cycles. At stop end:
  - if count!=0, pop and go directly to START with txd<=0, so there is no idle gap;
  - otherwise go to IDLE.
- Frame length is exactly 10*CLK_PER_BIT cycles.
- A new write during a frame never disturbs the frame in flight.

Outputs:
- txd is registered (no glitches).
- busy = (state!=IDLE) | (count!=0), registered form.
- fifo_full is registered and tracks count.

Test Plan:
- Bench uses CLK_PER_BIT=8, FIFO_DEPTH=4.
- Single byte: tx_ready pulse with 0xA5 at E0 -> txd falls after E1. Bit sequence is 0,1,0,1,0,0,1,0,1,1, each 8 cycles (80 total). busy high from E1 to frame end, then 0.
- Back-to-back burst: strobes 0x00,0x03,0x00,0x01 on consecutive cycles -> four contiguous frames, 320 cycles, no idle high between stop and next start. Bytes arrive in order. fifo_full never 1 (head popped at E1).
- Overflow: 6 consecutive strobes 0x10..0x15 into an idle block -> 0x10 popped at E1, 0x11..0x14 stored, fifo_full=1. 0x15 dropped and overflow=1. Exactly five frames 0x10..0x14 transmitted; overflow stays 1 afterwards.
- Simultaneous write and pop: one byte queued; strobe 0x7E on the exact cycle the stop bit ends -> count unchanged (1). Next frame starts without gap; 0x7E follows it.
- Reset mid-frame: assert rst during DATA bit 3 of 0xC3 -> txd=1 and busy=0 asynchronously, overflow=0. After release, strobe 0x5A -> normal 0x5A frame with correct timing.
- Idle line: no strobes for 1000 cycles after reset -> txd constantly 1, busy=0.
